// File: rtl/dds_nco_ctrl_if.sv
// dds_nco_ctrl_if: NCO control/sample bus.
//   CE     sample enable (accumulator and pipeline advance only when high)
//   WE     register write strobe, independent of CE
//   A      register address (0 FREQ shadow, 1 POFF shadow, 2 commit, 3 clear acc)
//   DATA   register write data, PHASE_W bits
//   SINE   signed sine sample, OUT_W bits
//   COSINE signed cosine sample, OUT_W bits
//   VALID  sample derived from a real phase
// The master modport is the controller/testbench side, the slave modport is the NCO.
interface dds_nco_ctrl_if #(
  parameter int PHASE_W = 27,
  parameter int OUT_W   = 10
);
  logic               CE;
  logic               WE;
  logic [4:0]         A;
  logic [PHASE_W-1:0] DATA;
  logic [OUT_W-1:0]   SINE;
  logic [OUT_W-1:0]   COSINE;
  logic               VALID;

  modport master (output CE, WE, A, DATA, input SINE, COSINE, VALID);
  modport slave  (input CE, WE, A, DATA, output SINE, COSINE, VALID);
endinterface

// File: rtl/dds_nco_ctrl.sv
// dds_nco_ctrl: quadrature NCO with shadowed frequency/phase registers.
// Ports:
//   CLK  sample clock (single domain)
//   RST  synchronous active-high reset, priority over WE and CE
//   bus  dds_nco_ctrl_if.slave: CE, WE, A, DATA in; SINE, COSINE, VALID out
// Phase accumulator -> S1 phase+offset -> S2 dual quarter-wave LUT read
// -> S3 sign/select into the output registers. Only the top LUT_AW+2 phase
// bits are kept after S1; the rest are truncated.
module dds_nco_ctrl #(
  parameter int          PHASE_W   = 27,
  parameter int          OUT_W     = 10,
  parameter int          LUT_AW    = 8,
  parameter int unsigned FREQ_INIT = 1253655
) (
  input logic           CLK,
  input logic           RST,
  dds_nco_ctrl_if.slave bus
);

  localparam int                 LUT_N    = 2 ** LUT_AW;
  localparam logic [PHASE_W-1:0] FREQ_RST = PHASE_W'(FREQ_INIT);

  // Quarter-wave entry k sampled at the bin centre, so L[k] and L[~k] form
  // an exact sine/cosine pair without a duplicated zero or peak entry.
  function automatic logic [OUT_W-1:0] lut_entry(input int k);
    real amp;
    real ang;
    amp = real'((2 ** (OUT_W - 1)) - 1);
    ang = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(LUT_N);
    return OUT_W'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  logic [OUT_W-1:0] lut [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    assign lut[k] = lut_entry(k);
  end

  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] freq_sh_q, freq_sh_d;
  logic [PHASE_W-1:0] poff_sh_q, poff_sh_d;
  logic [PHASE_W-1:0] freq_act_q, freq_act_d;
  logic [PHASE_W-1:0] poff_act_q, poff_act_d;
  logic [LUT_AW+1:0]  ph_q, ph_d;
  logic [1:0]         quad_q, quad_d;
  logic [OUT_W-1:0]   lut_a_q, lut_a_d;
  logic [OUT_W-1:0]   lut_b_q, lut_b_d;
  logic [OUT_W-1:0]   sine_q, sine_d;
  logic [OUT_W-1:0]   cosine_q, cosine_d;
  logic [2:0]         vld_q, vld_d;

  logic [LUT_AW-1:0]  idx;
  assign idx = ph_q[LUT_AW-1:0];

  always_comb begin
    acc_d      = acc_q;
    freq_sh_d  = freq_sh_q;
    poff_sh_d  = poff_sh_q;
    freq_act_d = freq_act_q;
    poff_act_d = poff_act_q;
    ph_d       = ph_q;
    quad_d     = quad_q;
    lut_a_d    = lut_a_q;
    lut_b_d    = lut_b_q;
    sine_d     = sine_q;
    cosine_d   = cosine_q;
    vld_d      = vld_q;

    if (bus.CE) begin
      acc_d   = acc_q + freq_act_q;
      ph_d    = (LUT_AW+2)'((acc_q + poff_act_q) >> (PHASE_W - LUT_AW - 2));
      quad_d  = ph_q[LUT_AW+1:LUT_AW];
      lut_a_d = lut[idx];
      lut_b_d = lut[~idx];
      case (quad_q)
        2'd0:    begin sine_d =  lut_a_q; cosine_d =  lut_b_q; end
        2'd1:    begin sine_d =  lut_b_q; cosine_d = -lut_a_q; end
        2'd2:    begin sine_d = -lut_a_q; cosine_d = -lut_b_q; end
        default: begin sine_d = -lut_b_q; cosine_d =  lut_a_q; end
      endcase
      vld_d = {vld_q[1:0], 1'b1};
    end

    if (bus.WE) begin
      case (bus.A)
        5'd0: freq_sh_d = bus.DATA;
        5'd1: poff_sh_d = bus.DATA;
        5'd2: begin
          freq_act_d = freq_sh_q;
          poff_act_d = poff_sh_q;
        end
        5'd3: acc_d = '0;  // overrides the CE increment on the same edge
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q      <= '0;
      freq_sh_q  <= FREQ_RST;
      poff_sh_q  <= '0;
      freq_act_q <= FREQ_RST;
      poff_act_q <= '0;
      ph_q       <= '0;
      quad_q     <= '0;
      lut_a_q    <= '0;
      lut_b_q    <= '0;
      sine_q     <= '0;
      cosine_q   <= '0;
      vld_q      <= '0;
    end else begin
      acc_q      <= acc_d;
      freq_sh_q  <= freq_sh_d;
      poff_sh_q  <= poff_sh_d;
      freq_act_q <= freq_act_d;
      poff_act_q <= poff_act_d;
      ph_q       <= ph_d;
      quad_q     <= quad_d;
      lut_a_q    <= lut_a_d;
      lut_b_q    <= lut_b_d;
      sine_q     <= sine_d;
      cosine_q   <= cosine_d;
      vld_q      <= vld_d;
    end
  end

  assign bus.SINE   = sine_q;
  assign bus.COSINE = cosine_q;
  assign bus.VALID  = vld_q[2];

endmodule

// File: tb/tb_dds_nco_ctrl.sv
module tb_dds_nco_ctrl;
  localparam int PW = 27;
  localparam int OW = 10;
  localparam int AW = 8;
  localparam logic [PW-1:0] F_INIT = 27'd1253655;
  localparam logic [PW-1:0] P2_25  = 27'h2000000;
  localparam logic [PW-1:0] P2_24  = 27'h1000000;
  localparam logic [PW-1:0] P_MAX  = 27'h7FFFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dds_nco_ctrl_if #(.PHASE_W(PW), .OUT_W(OW)) bus ();

  dds_nco_ctrl #(.PHASE_W(PW), .OUT_W(OW), .LUT_AW(AW), .FREQ_INIT(1253655)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int lut_ref[256];

  // Behavioural model: registers per the register map, plus the list of
  // phases captured on CE edges; the output is the phase captured two CE
  // edges earlier, mapped through the sine/cosine quadrant table.
  logic [PW-1:0] m_acc, m_fsh, m_psh, m_fact, m_pact;
  logic [PW-1:0] phq[$];
  logic          m_valid;
  logic [OW-1:0] m_sine, m_cos;

  function automatic void sample(input logic [PW-1:0] ph, output logic [OW-1:0] s,
                                 output logic [OW-1:0] c);
    int li, lc;
    li = lut_ref[ph[PW-3 -: AW]];
    lc = lut_ref[255 - int'(ph[PW-3 -: AW])];
    case (ph[PW-1 -: 2])
      2'd0:    begin s = OW'(li);  c = OW'(lc);  end
      2'd1:    begin s = OW'(lc);  c = OW'(-li); end
      2'd2:    begin s = OW'(-li); c = OW'(-lc); end
      default: begin s = OW'(-lc); c = OW'(li);  end
    endcase
  endfunction

  task automatic step(input logic r, input logic ce, input logic we,
                      input logic [4:0] a, input logic [PW-1:0] d);
    rst = r; bus.CE = ce; bus.WE = we; bus.A = a; bus.DATA = d;
    @(posedge clk);
    if (r) begin
      m_acc = '0; m_fsh = F_INIT; m_psh = '0; m_fact = F_INIT; m_pact = '0;
      phq.delete(); m_valid = 1'b0; m_sine = '0; m_cos = '0;
    end else begin
      if (ce) begin
        phq.push_back(m_acc + m_pact);
        if (phq.size() > 3) void'(phq.pop_front());
        m_valid = (phq.size() == 3);
        if (m_valid) sample(phq[0], m_sine, m_cos);
        m_acc = m_acc + m_fact;
      end
      if (we) begin
        case (a)
          5'd0: m_fsh = d;
          5'd1: m_psh = d;
          5'd2: begin m_fact = m_fsh; m_pact = m_psh; end
          5'd3: m_acc = '0;
          default: ;
        endcase
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 0, 0, '0);
    step(1, 1, 0, 0, '0);
    checks++;
    if (bus.SINE !== '0 || bus.COSINE !== '0 || bus.VALID !== 1'b0) begin
      errors++;
      $display("FAIL reset got %0d/%0d v%0b exp 0/0 v0", $signed(bus.SINE),
               $signed(bus.COSINE), bus.VALID);
    end
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 0, 0, '0);
      checks++;
      if (bus.VALID !== (i == 3)) begin
        errors++;
        $display("FAIL valid_rise edge %0d got %0b exp %0b", i, bus.VALID, (i == 3));
      end
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0, '0);
      checks++;
      if (bus.VALID !== m_valid || bus.SINE !== m_sine || bus.COSINE !== m_cos) begin
        errors++;
        $display("FAIL init_tone got %0d/%0d v%0b exp %0d/%0d v%0b", $signed(bus.SINE),
                 $signed(bus.COSINE), bus.VALID, $signed(m_sine), $signed(m_cos), m_valid);
      end
    end
  endtask

  task automatic test_quarter_tone();
    int sp[4] = '{2, 511, -2, -511};
    int cp[4] = '{511, -2, -511, 2};
    step(0, 1, 1, 5'd0, P2_25);
    step(0, 1, 1, 5'd2, '0);
    step(0, 1, 1, 5'd3, '0);
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0, 0, '0);
      checks++;
      if (bus.VALID !== m_valid || bus.SINE !== m_sine || bus.COSINE !== m_cos) begin
        errors++;
        $display("FAIL quarter_model got %0d/%0d exp %0d/%0d", $signed(bus.SINE),
                 $signed(bus.COSINE), $signed(m_sine), $signed(m_cos));
      end
      if (i >= 2) begin
        checks++;
        if ($signed(bus.SINE) != sp[(i-2)%4] || $signed(bus.COSINE) != cp[(i-2)%4]) begin
          errors++;
          $display("FAIL quarter_pattern got %0d/%0d exp %0d/%0d", $signed(bus.SINE),
                   $signed(bus.COSINE), sp[(i-2)%4], cp[(i-2)%4]);
        end
      end
    end
  endtask

  task automatic test_phase_offset();
    step(0, 1, 1, 5'd1, P2_25);
    step(0, 1, 1, 5'd2, '0);
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0, 0, '0);
      checks++;
      if (bus.VALID !== m_valid || bus.SINE !== m_sine || bus.COSINE !== m_cos) begin
        errors++;
        $display("FAIL phase_offset got %0d/%0d exp %0d/%0d", $signed(bus.SINE),
                 $signed(bus.COSINE), $signed(m_sine), $signed(m_cos));
      end
    end
  endtask

  task automatic test_shadow_isolation();
    step(0, 1, 1, 5'd0, P2_24);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 0, '0);
      checks++;
      if (bus.SINE !== m_sine || bus.COSINE !== m_cos) begin
        errors++;
        $display("FAIL shadow_hold got %0d/%0d exp %0d/%0d", $signed(bus.SINE),
                 $signed(bus.COSINE), $signed(m_sine), $signed(m_cos));
      end
    end
    step(0, 1, 1, 5'd2, '0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 0, '0);
      checks++;
      if (bus.SINE !== m_sine || bus.COSINE !== m_cos) begin
        errors++;
        $display("FAIL shadow_commit got %0d/%0d exp %0d/%0d", $signed(bus.SINE),
                 $signed(bus.COSINE), $signed(m_sine), $signed(m_cos));
      end
    end
  endtask

  task automatic test_ce_gating();
    for (int i = 0; i < 400; i++) begin
      logic ce, we;
      logic [4:0] a;
      ce = (i % 2 == 0) ? 1'b1 : 1'b0;
      if (i >= 100) ce = 1'($urandom_range(0, 1));
      we = ($urandom_range(0, 5) == 0);
      a  = 5'($urandom_range(0, 7));
      step(0, ce, we, a, PW'($urandom));
      checks++;
      if (bus.VALID !== m_valid || bus.SINE !== m_sine || bus.COSINE !== m_cos) begin
        errors++;
        $display("FAIL ce_gating cyc %0d got %0d/%0d v%0b exp %0d/%0d v%0b", i,
                 $signed(bus.SINE), $signed(bus.COSINE), bus.VALID, $signed(m_sine),
                 $signed(m_cos), m_valid);
      end
    end
  endtask

  task automatic test_mid_reset();
    step(0, 1, 1, 5'd0, P2_25);
    step(0, 1, 1, 5'd2, '0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, '0);
    step(1, 1, 1, 5'd0, P2_24);
    checks++;
    if (bus.SINE !== '0 || bus.COSINE !== '0 || bus.VALID !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got %0d/%0d v%0b exp 0/0 v0", $signed(bus.SINE),
               $signed(bus.COSINE), bus.VALID);
    end
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0, 0, '0);
      checks++;
      if (bus.VALID !== m_valid || (m_valid && (bus.SINE !== m_sine || bus.COSINE !== m_cos))) begin
        errors++;
        $display("FAIL after_reset got %0d/%0d v%0b exp %0d/%0d v%0b", $signed(bus.SINE),
                 $signed(bus.COSINE), bus.VALID, $signed(m_sine), $signed(m_cos), m_valid);
      end
    end
  endtask

  task automatic test_wrap();
    step(0, 1, 1, 5'd0, P_MAX);
    step(0, 1, 1, 5'd1, '0);
    step(0, 1, 1, 5'd2, '0);
    step(0, 1, 1, 5'd3, '0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 0, '0);
      checks++;
      if (bus.SINE !== m_sine || bus.COSINE !== m_cos) begin
        errors++;
        $display("FAIL wrap got %0d/%0d exp %0d/%0d", $signed(bus.SINE),
                 $signed(bus.COSINE), $signed(m_sine), $signed(m_cos));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++)
      lut_ref[k] = $rtoi(511.0 * $sin(3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / 256.0) + 0.5);
    bus.CE = 1'b0; bus.WE = 1'b0; bus.A = '0; bus.DATA = '0;
    test_reset();
    test_quarter_tone();
    test_phase_offset();
    test_shadow_isolation();
    test_ce_gating();
    test_mid_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
